// File: rtl/wb_commit_fifo.sv
// wb_commit_fifo: DEPTH-entry MEM->WB commit buffer carrying CH register
// writeback channels per beat, with a valid/ready handshake on both sides.
// The global rdy input freezes all state. The flush input discards all
// stored entries.
// Optional build macro WB_COMMIT_FWD_EN adds a combinational forwarding
// search over the occupied entries (ports fwd_addr, fwd_hit, fwd_data).
module wb_commit_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CH     = 1,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*DATA_W-1:0]         in_data,
  input  logic [CH*ADDR_W-1:0]         in_addr,
  input  logic [CH-1:0]                in_we,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [CH*DATA_W-1:0]         wb_data,
  output logic [CH*ADDR_W-1:0]         wb_addr,
  output logic [CH-1:0]                wb_we,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WB_COMMIT_FWD_EN
  ,
  input  logic [ADDR_W-1:0]            fwd_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CH*DATA_W-1:0] mem_data [DEPTH];
  logic [CH*ADDR_W-1:0] mem_addr [DEPTH];
  logic [CH-1:0]        mem_we   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CH-1:0] in_we_filt;
  logic          push;
  logic          pop;

  // Handshake flags depend only on the registered count, rdy and rst.
  // A full buffer refuses a push even when a pop happens in the same cycle.
  assign in_ready = ~rst & rdy & (count < CW'(DEPTH));
  assign wb_valid = ~rst & rdy & (count != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Head entry is presented only while valid. Otherwise it reads as zeros.
  assign wb_data = wb_valid ? mem_data[rd_ptr] : '0;
  assign wb_addr = wb_valid ? mem_addr[rd_ptr] : '0;
  assign wb_we   = wb_valid ? mem_we[rd_ptr]   : '0;

  // Writes to x0 are dropped at the input by clearing their enable.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no latch is inferred.
    in_we_filt = '0;
    for (int c = 0; c < CH; c++) begin
      in_we_filt[c] = in_we[c] & (in_addr[c*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Pointer and occupancy control: rst, then rdy hold, then flush, then push/pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (rdy) begin
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage. A flushed push is never written.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. The pointers and count alone
    // decide which entries are live, so stale contents are never visible.
    if (push && !flush) begin
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
      mem_we[wr_ptr]   <= in_we_filt;
    end
  end

`ifdef WB_COMMIT_FWD_EN
  // Forwarding search from the oldest to the youngest entry and from the
  // lowest to the highest channel. A later match overrides an earlier one,
  // so the youngest entry and then the highest channel wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = rd_ptr + PW'(j);
      if (j < int'(count)) begin
        for (int c = 0; c < CH; c++) begin
          if (mem_we[idx][c] && (fwd_addr != '0) &&
              (mem_addr[idx][c*ADDR_W +: ADDR_W] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_data[idx][c*DATA_W +: DATA_W];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit_fifo.sv
// tb_wb_commit_fifo: directed scoreboard bench for wb_commit_fifo (CH=2, DEPTH=2).
// The stimulus pushes the expected beat into a queue when it offers a beat
// that must be accepted. A monitor pops the queue on every completed
// writeback handshake and compares the head beat.
module tb_wb_commit_fifo;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [63:0] data;
    logic [9:0]  addr;
    logic [1:0]  we;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, wb_ready;
  logic        in_ready, wb_valid;
  logic [63:0] in_data, wb_data;
  logic [9:0]  in_addr, wb_addr;
  logic [1:0]  in_we, wb_we;
  logic [1:0]  count;
`ifdef WB_COMMIT_FWD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  beat_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_pops = 0;

  always #5 clk = ~clk;

  wb_commit_fifo #(.DATA_W(DW), .ADDR_W(AW), .CH(2), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .in_we    (in_we),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .count    (count)
`ifdef WB_COMMIT_FWD_EN
    ,
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for one cycle, check acceptance, queue it if accepted.
  task automatic offer(input string name, input logic [9:0] a, input logic [63:0] d,
                       input logic [1:0] we, input logic [1:0] exp_we, input logic acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_we    = we;
    @(negedge clk);
    check({name, " in_ready"}, 64'(in_ready), 64'(acc));
    if (acc) exp_q.push_back(beat_t'{d, a, exp_we});
    nxt();
    in_valid = 1'b0;
  endtask

  // Monitor: every completed writeback handshake must match the queue head.
  always @(negedge clk) begin
    if (wb_valid && wb_ready) begin
      beat_t e;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got addr 0x%0h expected no beat", wb_addr);
      end else begin
        e = exp_q.pop_front();
        check("pop data", wb_data, e.data);
        check("pop addr", 64'(wb_addr), 64'(e.addr));
        check("pop we", 64'(wb_we), 64'(e.we));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pops;
    exp_pops = 8;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    in_data = '0; in_addr = '0; in_we = '0;
`ifdef WB_COMMIT_FWD_EN
    fwd_addr = '0;
    exp_pops = 10;
`endif
    nxt();
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst wb_valid", 64'(wb_valid), 64'd0);
    check("rst count", 64'(count), 64'd0);
    check("rst wb_data", wb_data, 64'd0);
    nxt();
    rst = 1'b0;

    // First beat appears one cycle after the push.
    offer("t1", {5'd5, 5'd3}, {32'h22, 32'h11}, 2'b11, 2'b11, 1'b1);
    @(negedge clk);
    check("t1 wb_valid", 64'(wb_valid), 64'd1);
    check("t1 wb_addr", 64'(wb_addr), 64'({5'd5, 5'd3}));
    check("t1 count", 64'(count), 64'd1);
    nxt();
    wb_ready = 1'b1;
    nxt();
    wb_ready = 1'b0;

    // Fill to DEPTH, third beat refused, then drain in order.
    offer("b1", {5'd2, 5'd1}, {32'h200, 32'h100}, 2'b11, 2'b11, 1'b1);
    offer("b2", {5'd6, 5'd4}, {32'h400, 32'h300}, 2'b01, 2'b01, 1'b1);
    offer("b3", {5'd8, 5'd7}, {32'h600, 32'h500}, 2'b11, 2'b11, 1'b0);
    @(negedge clk);
    check("full count", 64'(count), 64'd2);
    nxt();
    wb_ready = 1'b1;
    nxt();
    nxt();
    wb_ready = 1'b0;
    @(negedge clk);
    check("drained count", 64'(count), 64'd0);
    check("empty wb_valid", 64'(wb_valid), 64'd0);
    check("empty wb_data", wb_data, 64'd0);
    check("empty wb_we", 64'(wb_we), 64'd0);
    nxt();

    // Full buffer refuses a push even while popping; push+pop keeps count.
    offer("b4", {5'd11, 5'd10}, {32'h4B, 32'h4A}, 2'b11, 2'b11, 1'b1);
    offer("b5", {5'd13, 5'd12}, {32'h5B, 32'h5A}, 2'b10, 2'b10, 1'b1);
    wb_ready = 1'b1;
    offer("b6_full", {5'd15, 5'd14}, {32'h6B, 32'h6A}, 2'b11, 2'b11, 1'b0);
    offer("b6", {5'd15, 5'd14}, {32'h6B, 32'h6A}, 2'b11, 2'b11, 1'b1);
    @(negedge clk);
    check("pushpop count", 64'(count), 64'd1);
    nxt();
    wb_ready = 1'b0;
    @(negedge clk);
    check("b6 drained count", 64'(count), 64'd0);
    nxt();

    // x0 filter: enable cleared, data kept.
    offer("x0", {5'd9, 5'd0}, {32'h1, 32'hDEAD}, 2'b11, 2'b10, 1'b1);
    @(negedge clk);
    check("x0 wb_we", 64'(wb_we), 64'b10);
    check("x0 wb_data", 64'(wb_data[31:0]), 64'hDEAD);
    nxt();
    offer("c2", {5'd17, 5'd16}, {32'hC2B, 32'hC2A}, 2'b11, 2'b11, 1'b1);
    @(negedge clk);
    check("preflush count", 64'(count), 64'd2);
    nxt();

    // Flush wins over a simultaneous push.
    flush = 1'b1;
    in_valid = 1'b1;
    in_addr = {5'd19, 5'd18};
    in_data = {32'hC3B, 32'hC3A};
    in_we = 2'b11;
    nxt();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush count", 64'(count), 64'd0);
    check("flush wb_valid", 64'(wb_valid), 64'd0);
    nxt();

    // rdy=0 freezes state and blocks both handshakes.
    offer("d1", {5'd21, 5'd20}, {32'hD1B, 32'hD1A}, 2'b11, 2'b11, 1'b1);
    rdy = 1'b0;
    in_valid = 1'b1;
    in_addr = {5'd23, 5'd22};
    in_data = {32'hD2B, 32'hD2A};
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold in_ready", 64'(in_ready), 64'd0);
      check("hold wb_valid", 64'(wb_valid), 64'd0);
      check("hold count", 64'(count), 64'd1);
      nxt();
    end
    rdy = 1'b1;
    in_valid = 1'b0;
    nxt();
    wb_ready = 1'b0;
    @(negedge clk);
    check("unhold count", 64'(count), 64'd0);
    nxt();

    // Reset mid-operation loses stored entries.
    offer("e1", {5'd25, 5'd24}, {32'hE1B, 32'hE1A}, 2'b11, 2'b11, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    check("midrst wb_valid", 64'(wb_valid), 64'd0);
    nxt();
    exp_q.delete();
    @(negedge clk);
    check("midrst count", 64'(count), 64'd0);
    nxt();
    rst = 1'b0;
    offer("e2", {5'd27, 5'd26}, {32'hE2B, 32'hE2A}, 2'b11, 2'b11, 1'b1);
    wb_ready = 1'b1;
    nxt();
    wb_ready = 1'b0;

`ifdef WB_COMMIT_FWD_EN
    // Youngest entry wins the forwarding search.
    offer("f1", {5'd2, 5'd7}, {32'h5, 32'hA}, 2'b11, 2'b11, 1'b1);
    offer("f2", {5'd7, 5'd3}, {32'hB, 32'hC}, 2'b11, 2'b11, 1'b1);
    fwd_addr = 5'd7;
    #1;
    check("fwd7 hit", 64'(fwd_hit), 64'd1);
    check("fwd7 data", 64'(fwd_data), 64'hB);
    fwd_addr = 5'd2;
    #1;
    check("fwd2 data", 64'(fwd_data), 64'h5);
    fwd_addr = 5'd0;
    #1;
    check("fwd0 hit", 64'(fwd_hit), 64'd0);
    check("fwd0 data", 64'(fwd_data), 64'd0);
    nxt();
    wb_ready = 1'b1;
    nxt();
    nxt();
    wb_ready = 1'b0;
`endif

    @(negedge clk);
    check("end queue empty", 64'(exp_q.size()), 64'd0);
    check("end pop total", 64'(n_pops), 64'(exp_pops));
    check("end count", 64'(count), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
